// File: rtl/pll_lock_supervisor_if.sv
// rtl/pll_lock_supervisor_if.sv - PLL-side and status signals of the lock supervisor
interface pll_lock_supervisor_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   pll_lock;
  logic                   clr_lost;
  logic                   pll_pwd;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   all_ready;
  logic                   lock_lost;
  logic [7:0]             retry_cnt;
  logic                   pll_fail;
  logic [2:0]             state_o;

  modport master (
    input  pll_lock, clr_lost,
    output pll_pwd, pll_rst, dom_rst, all_ready, lock_lost, retry_cnt, pll_fail, state_o
  );

  modport slave (
    output pll_lock, clr_lost,
    input  pll_pwd, pll_rst, dom_rst, all_ready, lock_lost, retry_cnt, pll_fail, state_o
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL bring-up, lock qualification and staggered domain reset release; PLL_SUP_RETRY_LIMIT_EN enables the FAIL state
module pll_lock_supervisor #(
  parameter int NUM_DOMAINS  = 4,
  parameter int PWD_CYCLES   = 16,
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_FILT    = 256,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RELEASE_GAP  = 16,
  parameter int MAX_RETRY    = 7
) (
  input  logic                     clkin1,
  input  logic                     rst,
  pll_lock_supervisor_if.master    bus
);

  localparam int REL_END = NUM_DOMAINS * RELEASE_GAP;
  localparam int M1      = (PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES;
  localparam int M2      = (M1 > LOCK_TIMEOUT) ? M1 : LOCK_TIMEOUT;
  localparam int CNT_MAX = (M2 > REL_END) ? M2 : REL_END;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FW      = $clog2(LOCK_FILT + 1);

  typedef enum logic [2:0] {
    S_PWRDN   = 3'd0,
    S_RST     = 3'd1,
    S_WAIT    = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [FW-1:0]          filt, filt_nxt;
  logic [7:0]             retry, retry_nxt;
  logic                   lost, lost_nxt;
  logic                   sync1, lock_s;
  logic                   pwd_q, prst_q, rdy_q, fail_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic                   pwd_d, prst_d, rdy_d, fail_d;
  logic [NUM_DOMAINS-1:0] dom_d;
  logic                   loss;

  always_ff @(posedge clkin1) begin
    if (rst) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
      state  <= S_PWRDN;
      cnt    <= '0;
      filt   <= '0;
      retry  <= 8'd0;
      lost   <= 1'b0;
      pwd_q  <= 1'b1;
      prst_q <= 1'b1;
      dom_q  <= '1;
      rdy_q  <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      sync1  <= bus.pll_lock;
      lock_s <= sync1;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      filt   <= filt_nxt;
      retry  <= retry_nxt;
      lost   <= lost_nxt;
      pwd_q  <= pwd_d;
      prst_q <= prst_d;
      dom_q  <= dom_d;
      rdy_q  <= rdy_d;
      fail_q <= fail_d;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    filt_nxt  = '0;
    retry_nxt = retry;
    loss      = 1'b0;
    case (state)
      S_PWRDN: begin
        if (cnt == CW'(PWD_CYCLES - 1)) begin
          state_nxt = S_RST;
          cnt_nxt   = '0;
        end
      end
      S_RST: begin
        if (cnt == CW'(RST_CYCLES - 1)) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        filt_nxt = lock_s ? filt + FW'(1) : '0;
        // A filter completion on the timeout cycle still counts as lock.
        if (lock_s && filt == FW'(LOCK_FILT - 1)) begin
          state_nxt = S_RELEASE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          cnt_nxt = '0;
`ifdef PLL_SUP_RETRY_LIMIT_EN
          if (retry == 8'(MAX_RETRY)) begin
            state_nxt = S_FAIL;
          end else begin
            state_nxt = S_RST;
            retry_nxt = (retry == 8'hFF) ? retry : retry + 8'd1;
          end
`else
          state_nxt = S_RST;
          retry_nxt = (retry == 8'hFF) ? retry : retry + 8'd1;
`endif
        end
      end
      S_RELEASE: begin
        if (!lock_s) begin
          loss      = 1'b1;
          state_nxt = S_RST;
          cnt_nxt   = '0;
        end else if (cnt == CW'(REL_END)) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        cnt_nxt = cnt;
        if (!lock_s) begin
          loss      = 1'b1;
          state_nxt = S_RST;
          cnt_nxt   = '0;
        end
      end
      S_FAIL: begin
        cnt_nxt = cnt;
      end
      default: begin
        state_nxt = S_PWRDN;
        cnt_nxt   = '0;
      end
    endcase
    // A new loss outranks a clear arriving on the same edge.
    lost_nxt = loss ? 1'b1 : (bus.clr_lost ? 1'b0 : lost);
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pwd_d  = 1'b0;
    prst_d = 1'b0;
    dom_d  = '1;
    rdy_d  = 1'b0;
    fail_d = 1'b0;
    case (state_nxt)
      S_PWRDN: begin
        pwd_d  = 1'b1;
        prst_d = 1'b1;
      end
      S_RST: begin
        prst_d = 1'b1;
      end
      S_RELEASE: begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
          dom_d[i] = (cnt_nxt < CW'((i + 1) * RELEASE_GAP));
        end
      end
      S_RUN: begin
        dom_d = '0;
        rdy_d = 1'b1;
      end
      S_FAIL: begin
        pwd_d  = 1'b1;
        prst_d = 1'b1;
`ifdef PLL_SUP_RETRY_LIMIT_EN
        fail_d = 1'b1;
`endif
      end
      default: begin
        dom_d = '1;
      end
    endcase
  end

`ifndef PLL_SUP_RETRY_LIMIT_EN
  logic unused_retry_cfg;
  assign unused_retry_cfg = ^(8'(MAX_RETRY));
`endif

  assign bus.pll_pwd   = pwd_q;
  assign bus.pll_rst   = prst_q;
  assign bus.dom_rst   = dom_q;
  assign bus.all_ready = rdy_q;
  assign bus.lock_lost = lost;
  assign bus.retry_cnt = retry;
  assign bus.pll_fail  = fail_q;
  assign bus.state_o   = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed vector bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor_if #(.NUM_DOMAINS(3)) bus ();

  pll_lock_supervisor #(
    .NUM_DOMAINS (3),
    .PWD_CYCLES  (4),
    .RST_CYCLES  (8),
    .LOCK_FILT   (10),
    .LOCK_TIMEOUT(100),
    .RELEASE_GAP (5),
    .MAX_RETRY   (2)
  ) dut (
    .clkin1(clk),
    .rst   (rst),
    .bus   (bus)
  );

  logic [18:0] obs;
  assign obs = {bus.pll_pwd, bus.pll_rst, bus.dom_rst, bus.all_ready, bus.lock_lost,
                bus.retry_cnt, bus.pll_fail, bus.state_o};

  typedef struct {
    int       cyc;
    bit       pwd;
    bit       prst;
    bit [2:0] dom;
    bit       rdy;
    bit [2:0] st;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [18:0] mk(input bit pwd, input bit prst, input bit [2:0] dom,
                                     input bit rdy, input bit lost, input bit [7:0] retry,
                                     input bit fail, input bit [2:0] st);
    return {pwd, prst, dom, rdy, lost, retry, fail, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic check(input string name, input logic [18:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got pwd/rst/dom/rdy/lost/retry/fail/st=%b want %b",
               name, cyc, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    bus.pll_lock = 1'b1;
    bus.clr_lost = 1'b0;

    tbl[0]  = '{0,  1'b1, 1'b1, 3'b111, 1'b0, 3'd0};
    tbl[1]  = '{3,  1'b1, 1'b1, 3'b111, 1'b0, 3'd0};
    tbl[2]  = '{4,  1'b0, 1'b1, 3'b111, 1'b0, 3'd1};
    tbl[3]  = '{11, 1'b0, 1'b1, 3'b111, 1'b0, 3'd1};
    tbl[4]  = '{12, 1'b0, 1'b0, 3'b111, 1'b0, 3'd2};
    tbl[5]  = '{21, 1'b0, 1'b0, 3'b111, 1'b0, 3'd2};
    tbl[6]  = '{22, 1'b0, 1'b0, 3'b111, 1'b0, 3'd3};
    tbl[7]  = '{26, 1'b0, 1'b0, 3'b111, 1'b0, 3'd3};
    tbl[8]  = '{27, 1'b0, 1'b0, 3'b110, 1'b0, 3'd3};
    tbl[9]  = '{31, 1'b0, 1'b0, 3'b110, 1'b0, 3'd3};
    tbl[10] = '{32, 1'b0, 1'b0, 3'b100, 1'b0, 3'd3};
    tbl[11] = '{36, 1'b0, 1'b0, 3'b100, 1'b0, 3'd3};
    tbl[12] = '{37, 1'b0, 1'b0, 3'b000, 1'b0, 3'd3};
    tbl[13] = '{38, 1'b0, 1'b0, 3'b000, 1'b1, 3'd4};

    // Nominal bring-up with lock held high from reset
    do_reset();
    for (int i = 0; i < 14; i++) begin
      run_to(tbl[i].cyc);
      check($sformatf("bringup_c%0d", tbl[i].cyc),
            mk(tbl[i].pwd, tbl[i].prst, tbl[i].dom, tbl[i].rdy, 1'b0, 8'd0, 1'b0, tbl[i].st));
    end

    // Single-cycle lock drop in RUN, then clr_lost on its own
    run_to(40);
    bus.pll_lock = 1'b0;
    tick();
    bus.pll_lock = 1'b1;
    run_to(42);
    check("loss1_pre", mk(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'd0, 1'b0, 3'd4));
    tick();
    check("loss1_hit", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b1, 8'd0, 1'b0, 3'd1));
    run_to(45);
    bus.clr_lost = 1'b1;
    tick();
    bus.clr_lost = 1'b0;
    check("clr_alone", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 1'b0, 3'd1));
    run_to(50);
    check("loss1_rst_end", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 1'b0, 3'd1));
    tick();
    check("loss1_wait", mk(1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 1'b0, 3'd2));
    run_to(77);
    check("rerelease_run", mk(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 8'd0, 1'b0, 3'd4));

    // Second loss with clr_lost landing on the same edge
    run_to(80);
    bus.pll_lock = 1'b0;
    tick();
    bus.pll_lock = 1'b1;
    run_to(82);
    bus.clr_lost = 1'b1;
    tick();
    bus.clr_lost = 1'b0;
    check("loss2_clr_same", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b1, 8'd0, 1'b0, 3'd1));

    // Reset one cycle after dom_rst[0] falls during re-release
    run_to(106);
    check("rerelease_dom0", mk(1'b0, 1'b0, 3'b110, 1'b0, 1'b1, 8'd0, 1'b0, 3'd3));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_release_rst", mk(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0));

    // Lock toggling every 6 cycles never satisfies the filter
    do_reset();
    while (cyc < 112) begin
      bus.pll_lock = ((cyc / 6) % 2 == 0);
      tick();
      if (cyc == 111)
        check("toggle_pre_tmo", mk(1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 1'b0, 3'd2));
    end
    check("toggle_tmo", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd1, 1'b0, 3'd1));

    // Lock held low: repeated timeouts
    bus.pll_lock = 1'b0;
    do_reset();
    run_to(220);
    check("tmo2", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd2, 1'b0, 3'd1));
    run_to(327);
    check("tmo3_pre", mk(1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 8'd2, 1'b0, 3'd2));
    tick();
`ifdef PLL_SUP_RETRY_LIMIT_EN
    check("tmo3_fail", mk(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 8'd2, 1'b1, 3'd5));
    bus.pll_lock = 1'b1;
    run_to(340);
    check("fail_sticky", mk(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 8'd2, 1'b1, 3'd5));
`else
    check("tmo3_retry", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd3, 1'b0, 3'd1));
    bus.pll_lock = 1'b1;
    run_to(340);
    check("tmo3_wait", mk(1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 8'd3, 1'b0, 3'd2));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
